// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run-control sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, DONE} run_state_t;

    localparam int DEF_NUM_PROGS = 3;
    localparam int DEF_PC_WIDTH  = 10;

    // Program start addresses, index 0 first.
    localparam logic [0:DEF_NUM_PROGS-1][DEF_PC_WIDTH-1:0] DEF_PROG_BASE =
        {10'd0, 10'd256, 10'd512};

    // Width of the program-select field; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host/PC-side signal bundle of the run-control sequencer.
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int NUM_PROGS = DEF_NUM_PROGS,
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int CYC_WIDTH = 16
);
    localparam int SEL_W = sel_width(NUM_PROGS);

    logic                 Start;
    logic [SEL_W-1:0]     ProgSel;
    logic                 Halt;
    logic                 CountEn;
    logic                 PcLoad;
    logic [PC_WIDTH-1:0]  PcLoadVal;
    logic                 Done;
    logic                 Timeout;
    logic                 BadSel;
    logic [CYC_WIDTH-1:0] CycleCount;
    logic [SEL_W-1:0]     ProgId;

    modport master (
        output Start, ProgSel, Halt,
        input  CountEn, PcLoad, PcLoadVal, Done, Timeout, BadSel, CycleCount, ProgId
    );

    modport slave (
        input  Start, ProgSel, Halt,
        output CountEn, PcLoad, PcLoadVal, Done, Timeout, BadSel, CycleCount, ProgId
    );

endinterface

// File: rtl/run_cyc_ctr.sv
// Saturating run-cycle counter with clear, enable and a terminal flag one
// count before the limit.
module run_cyc_ctr #(
    parameter int CYC_WIDTH  = 16,
    parameter int MAX_CYCLES = 16'hFFFF
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Clr,
    input  logic                 En,
    output logic [CYC_WIDTH-1:0] Count,
    output logic                 Term
);
    localparam logic [CYC_WIDTH-1:0] MAX_VAL  = CYC_WIDTH'(MAX_CYCLES);
    localparam logic [CYC_WIDTH-1:0] TERM_VAL = CYC_WIDTH'(MAX_CYCLES - 1);

    // Count enabled cycles, stopping at the limit; clear has priority.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            Count <= '0;
        else if (Clr)
            Count <= '0;
        else if (En && (Count != MAX_VAL))
            Count <= Count + CYC_WIDTH'(1);
    end

    assign Term = (Count == TERM_VAL);

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: arms on Start, loads the PC with the selected
// program base, enables counting while running, ends on Halt or cycle limit.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_PROGS  = DEF_NUM_PROGS,
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int CYC_WIDTH  = 16,
    parameter int MAX_CYCLES = 16'hFFFF,
    parameter logic [0:NUM_PROGS-1][PC_WIDTH-1:0] PROG_BASE = DEF_PROG_BASE
) (
    input  logic       Clk,
    input  logic       Rst_n,
    run_ctrl_if.slave  bus
);
    localparam int SEL_W = sel_width(NUM_PROGS);

    run_state_t           state, state_nxt;
    logic [SEL_W-1:0]     prog_id;
    logic                 timeout_q;
    logic                 badsel_q;
    logic                 arm_cap;
    logic                 sel_bad;
    logic                 term;
    logic [CYC_WIDTH-1:0] cyc_cnt;
    logic                 count_en;
    logic                 pc_load;
    logic                 done;
    logic [PC_WIDTH-1:0]  pc_load_val;

    // The Start fall in ARMED is the single point where a run is committed.
    assign arm_cap = (state == ARMED) && !bus.Start;
    assign sel_bad = int'(bus.ProgSel) >= NUM_PROGS;

    run_cyc_ctr #(
        .CYC_WIDTH  (CYC_WIDTH),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cyc (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clr   (arm_cap),
        .En    (count_en),
        .Count (cyc_cnt),
        .Term  (term)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs; Halt beats the limit in RUN.
    always_comb begin
        state_nxt   = state;
        count_en    = 1'b0;
        pc_load     = 1'b0;
        done        = 1'b0;
        pc_load_val = '0;
        case (state)
            IDLE:  if (bus.Start) state_nxt = ARMED;
            ARMED: if (!bus.Start) state_nxt = sel_bad ? DONE : LOAD;
            LOAD: begin
                pc_load   = 1'b1;
                if (int'(prog_id) < NUM_PROGS)
                    pc_load_val = PROG_BASE[prog_id];
                state_nxt = RUN;
            end
            RUN: begin
                count_en = 1'b1;
                if (bus.Halt || term) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.Start) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run status: captured at arm, timeout flagged only when Halt is absent.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prog_id   <= '0;
            timeout_q <= 1'b0;
            badsel_q  <= 1'b0;
        end else if (arm_cap) begin
            prog_id   <= bus.ProgSel;
            timeout_q <= 1'b0;
            badsel_q  <= sel_bad;
        end else if ((state == RUN) && term && !bus.Halt) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.CountEn    = count_en;
    assign bus.PcLoad     = pc_load;
    assign bus.PcLoadVal  = pc_load_val;
    assign bus.Done       = done;
    assign bus.Timeout    = timeout_q;
    assign bus.BadSel     = badsel_q;
    assign bus.CycleCount = cyc_cnt;
    assign bus.ProgId     = prog_id;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run-control sequencer for the 3BC processor; replaces the single-bit PC count-enable state. It detects a Start pulse, loads the PC with the selected program's base address, gates PC counting while the program runs, and ends the run on processor Halt or a cycle-limit timeout. It sits between the testbench or host and the program counter, feeding the PC's load and count-enable inputs.

## Interface
- NUM_PROGS, 3: number of selectable programs (1..16).
- PC_WIDTH, 10: program counter width.
- CYC_WIDTH, 16: cycle counter width.
- MAX_CYCLES, 16'hFFFF: run cycle limit (1..2^CYC_WIDTH-1).
- PROG_BASE, {10'd0, 10'd256, 10'd512}: packed array `[NUM_PROGS][PC_WIDTH]` of program start addresses.
- Clk  in  1  processor clock; all state on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  run request from testbench/host; synchronous to Clk.
- ProgSel  in  $clog2(NUM_PROGS) (min 1)  program index; sampled on the Start falling edge.
- Halt  in  1  processor halt indication; single-cycle or level.
- CountEn  out  1  PC count enable.
- PcLoad  out  1  one-cycle PC load strobe.
- PcLoadVal  out  PC_WIDTH  address to load; valid while PcLoad=1.
- Done  out  1  run finished; held until the next Start rise.
- Timeout  out  1  the finished run ended by cycle limit; qualified by Done.
- BadSel  out  1  the run was rejected because ProgSel >= NUM_PROGS; qualified by Done.
- CycleCount  out  CYC_WIDTH  cycles spent in RUN during the current or last run.
- ProgId  out  ProgSel width  program index captured for the current or last run.

## Operation
- States: IDLE, ARMED, LOAD, RUN, DONE.
- IDLE:
  - Start=1 → ARMED.
- ARMED:
  - Wait for Start=0.
  - On that cycle, capture ProgSel into ProgId and clear CycleCount, Timeout and BadSel.
  - Valid index → LOAD.
  - ProgSel >= NUM_PROGS → DONE with BadSel=1.
- LOAD:
  - PcLoad=1 and PcLoadVal=PROG_BASE[ProgId] for exactly one cycle.
  - Next state is RUN.
  - Halt is ignored in LOAD.
- RUN:
  - CountEn=1; CycleCount increments each cycle, saturating at MAX_CYCLES.
  - Halt=1 → DONE.
  - CycleCount==MAX_CYCLES-1 with Halt=0 → DONE with Timeout=1.
  - Halt and the timeout condition in the same cycle: Halt wins, Timeout=0.
  - Start=1 in RUN is ignored.
- DONE:
  - Done=1; CycleCount, ProgId, Timeout and BadSel hold their values.
  - Start=1 → ARMED, and Done clears.
- Reset value of every output is 0; the state resets to IDLE.
- PcLoadVal is 0 whenever PcLoad=0.
- Rst_n asserted in any state, including mid-RUN:
  - Outputs go to 0 immediately (asynchronously).
  - No DONE is produced for the aborted run.
- All outputs are registered or decoded directly from the state; there is no combinational path from any input to any output.

## Timing
- Start falling edge (cycle N, first Start=0 sample in ARMED) → PcLoad=1 in cycle N+1 → CountEn=1 from cycle N+2.
- Halt sampled high in RUN at cycle M:
  - CountEn=0 and Done=1 from cycle M+1.
  - CycleCount is frozen at its value in cycle M+1, which counts the Halt cycle.
- Timeout: after MAX_CYCLES RUN cycles, Done=1 and Timeout=1 on the following cycle, with CycleCount=MAX_CYCLES.
- BadSel: Done=1 on cycle N+1. PcLoad and CountEn never assert.
- A Start pulse of one cycle is sufficient. A Start held high stays in ARMED indefinitely.
- Back-to-back runs: the Start rise in DONE is accepted the same cycle, so there are no dead cycles.

## Structure
- Shared package run_ctrl_pkg holds:
  - the state enum run_state_t {IDLE, ARMED, LOAD, RUN, DONE};
  - the default PROG_BASE constant;
  - the helper function for the ProgSel width.
- One sub-module, run_cyc_ctr: a saturating CYC_WIDTH counter with clear, enable, and a terminal flag at MAX_CYCLES-1.
- The FSM and output decode stay in run_ctrl.

## Test plan
- Reset, then Start high 3 cycles then low with ProgSel=1 → PcLoad one cycle with PcLoadVal=256, then CountEn=1 from the next cycle; Done=0.
- Run program 0, raise Halt after 20 RUN cycles → CountEn falls next cycle, Done=1, CycleCount=20, Timeout=0, ProgId=0.
- MAX_CYCLES=8, no Halt → Done=1 and Timeout=1 after 8 RUN cycles with CycleCount=8; Halt asserted on RUN cycle 8 instead → Timeout=0.
- ProgSel=3 with NUM_PROGS=3 → Done=1 and BadSel=1 one cycle after the Start fall; PcLoad and CountEn stay 0.
- Halt pulsed during LOAD, and Start pulsed mid-RUN → both ignored; the run continues; CycleCount is unaffected.
- Rst_n low mid-RUN with CycleCount=5 → all outputs 0 at once, no Done; after release, the next Start runs normally with CycleCount restarting at 0.
